// File: rtl/fcl_uart_tx.sv
// RBus-mapped UART transmitter: a byte FIFO feeding an 8N1 serialiser on uart_tx_out.
// Define FCL_UART_TX_PARITY_EN to insert an even-parity bit and send 8E1 frames.
module fcl_uart_tx #(
  parameter int unsigned                 SYS_CLK_FREQ    = 32'd125000000,
  parameter int unsigned                 UART_BAUD_RATE  = 32'd115200,
  parameter int unsigned                 RBUS_ADDR_WIDTH = 32'd16,
  parameter int unsigned                 RBUS_DATA_WIDTH = 32'd16,
  parameter logic [RBUS_ADDR_WIDTH-1:0]  RBUS_OFFSET     = 16'h3000,
  parameter int unsigned                 FIFO_DEPTH_LOG2 = 32'd4
) (
  input  logic                       sys_clk_buf,
  input  logic                       sys_reset,
  input  logic [RBUS_DATA_WIDTH-1:0] rbus_data_in,
  input  logic [RBUS_ADDR_WIDTH-1:0] rbus_addr_in,
  input  logic                       rbus_read_in,
  input  logic                       rbus_write_in,
  output logic [RBUS_DATA_WIDTH-1:0] rbus_data_out,
  output logic                       rbus_ack_out,
  output logic                       uart_tx_out,
  output logic                       busy_out
);

  localparam int unsigned BAUD_DIV = (SYS_CLK_FREQ + UART_BAUD_RATE / 32'd2) / UART_BAUD_RATE;
  localparam int unsigned CNT_W    = (BAUD_DIV > 32'd1) ? $clog2(BAUD_DIV) : 32'd1;
  localparam int unsigned DEPTH    = 32'd1 << FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W    = FIFO_DEPTH_LOG2 + 32'd1;

  localparam logic [CNT_W-1:0]           CNT_MAX   = CNT_W'(BAUD_DIV - 32'd1);
  localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]           CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [LVL_W-1:0]           LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]           LVL_ZERO  = LVL_W'(32'd0);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(32'd1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ZERO  = FIFO_DEPTH_LOG2'(32'd0);
  localparam logic [RBUS_ADDR_WIDTH-1:0] STAT_ADDR = RBUS_OFFSET + RBUS_ADDR_WIDTH'(32'd1);
  localparam logic [RBUS_DATA_WIDTH-1:0] DATA_ZERO = {RBUS_DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t                     state_r, state_n;
  logic [CNT_W-1:0]           cnt_r, cnt_n;
  logic [2:0]                 idx_r, idx_n;
  logic [7:0]                 data_r, data_n;
  logic                       tx_n, tx_r;
  logic                       busy_r;

  logic [7:0]                 mem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]           level_r;
  logic                       ovf_r;
  logic                       push_pend_r;
  logic [7:0]                 push_byte_r;
  logic                       ack_r;
  logic [RBUS_DATA_WIDTH-1:0] rdata_r;
  logic [RBUS_DATA_WIDTH-1:0] status_s;

  logic sel_data_s, sel_stat_s, flush_s, ovf_clr_s;
  logic empty_s, full_s, baud_end_s, pop_req_s, pop_s, push_ok_s, ovf_set_s;
  logic [7:0] head_s;
  logic unused_s;

  assign sel_data_s = (rbus_addr_in == RBUS_OFFSET);
  assign sel_stat_s = (rbus_addr_in == STAT_ADDR);
  assign flush_s    = rbus_write_in & sel_stat_s & rbus_data_in[15];
  assign ovf_clr_s  = rbus_write_in & sel_stat_s & rbus_data_in[3];
  assign unused_s   = ^rbus_data_in;

  assign empty_s    = (level_r == LVL_ZERO);
  assign full_s     = (level_r == LVL_FULL);
  assign head_s     = mem_r[rd_ptr_r];
  assign baud_end_s = (cnt_r == CNT_MAX);

  // The serialiser pops at the end of IDLE or STOP; a flush in the same cycle cancels it.
  assign pop_req_s  = ~empty_s & ((state_r == ST_IDLE) | ((state_r == ST_STOP) & baud_end_s));
  assign pop_s      = pop_req_s & ~flush_s;
  assign push_ok_s  = push_pend_r & ~flush_s & (~full_s | pop_s);
  assign ovf_set_s  = push_pend_r & ~flush_s & full_s & ~pop_s;

  // Status word as seen at the current edge.
  always_comb begin
    status_s                = DATA_ZERO;
    status_s[0]             = (state_r != ST_IDLE);
    status_s[1]             = full_s;
    status_s[2]             = empty_s;
    status_s[3]             = ovf_r;
    status_s[8 +: LVL_W]    = level_r;
  end

  // Bus response and the one-cycle delayed DATA push.
  always_ff @(posedge sys_clk_buf or posedge sys_reset) begin
    if (sys_reset) begin
      ack_r       <= 1'b0;
      rdata_r     <= DATA_ZERO;
      push_pend_r <= 1'b0;
      push_byte_r <= 8'h00;
    end else begin
      ack_r       <= (rbus_read_in | rbus_write_in) & (sel_data_s | sel_stat_s);
      rdata_r     <= (rbus_read_in & sel_stat_s) ? status_s : DATA_ZERO;
      push_pend_r <= rbus_write_in & sel_data_s;
      push_byte_r <= rbus_data_in[7:0];
    end
  end

  // FIFO pointers, fill level and sticky overflow.
  always_ff @(posedge sys_clk_buf or posedge sys_reset) begin
    if (sys_reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
        level_r  <= LVL_ZERO;
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
        level_r <= level_r + LVL_W'(push_ok_s) - LVL_W'(pop_s);
      end
      if (ovf_set_s)      ovf_r <= 1'b1;
      else if (ovf_clr_s) ovf_r <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while the level says empty.
  always_ff @(posedge sys_clk_buf) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_byte_r;
  end

  // Serialiser state register.
  always_ff @(posedge sys_clk_buf or posedge sys_reset) begin
    if (sys_reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      data_r  <= 8'h00;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      data_r  <= data_n;
    end
  end

  // Serialiser next-state logic.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    data_n  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_n = ST_START;
          cnt_n   = CNT_ZERO;
          data_n  = head_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          state_n = ST_DATA;
          cnt_n   = CNT_ZERO;
          idx_n   = 3'd0;
        end else begin
          cnt_n   = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (baud_end_s) begin
          cnt_n = CNT_ZERO;
          idx_n = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
`ifdef FCL_UART_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            state_n = ST_DATA;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (baud_end_s) begin
          state_n = ST_STOP;
          cnt_n   = CNT_ZERO;
        end else begin
          cnt_n   = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (baud_end_s) begin
          cnt_n = CNT_ZERO;
          if (pop_s) begin
            state_n = ST_START;
            data_n  = head_s;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = CNT_ZERO;
        idx_n   = 3'd0;
      end
    endcase
  end

  // Line level for the upcoming state, so the pin register changes with the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_IDLE:   tx_n = 1'b1;
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = data_n[idx_n];
      ST_PARITY: tx_n = even_parity(data_n);
      ST_STOP:   tx_n = 1'b1;
      default:   tx_n = 1'b1;
    endcase
  end

  // Registered serial line and busy flag.
  always_ff @(posedge sys_clk_buf or posedge sys_reset) begin
    if (sys_reset) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_n;
      busy_r <= (state_r != ST_IDLE) | ~empty_s;
    end
  end

  assign uart_tx_out   = tx_r;
  assign busy_out      = busy_r;
  assign rbus_ack_out  = ack_r;
  assign rbus_data_out = rdata_r;

endmodule
